// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes, FSM state type and default width for shift_unit
// SHIFT_ROTATE_EN enables ROL/ROR as shift ops; otherwise they decode as NOP.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    logic ok;
    ok = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef SHIFT_ROTATE_EN
    ok = ok || (op == OP_ROL) || (op == OP_ROR);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-bit shift/rotate step
// Rotate cases exist only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SLL:  o_data = {i_data[WIDTH-2:0], 1'b0};
      OP_SRL:  o_data = {1'b0, i_data[WIDTH-1:1]};
      OP_SRA:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROL:  o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
      OP_ROR:  o_data = {i_data[0], i_data[WIDTH-1:1]};
`endif
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle shifter, one bit per cycle, IDLE/SHIFT/DONE FSM
// Rotates (ROL/ROR) are built only when SHIFT_ROTATE_EN is defined.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] w_step_data;
  logic             w_in_shift;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;

  assign w_in_shift = (r_state == ST_SHIFT);
  // Requests are only taken outside SHIFT; NOP/reserved never count as accepted.
  assign w_accept   = start && !w_in_shift;
  assign w_load     = w_accept && (op == OP_LOAD);
  assign w_shift    = w_accept && is_shift_op(op);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_op   (r_op),
    .i_data (r_data),
    .o_data (w_step_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_load) begin
          w_next_state = ST_DONE;
        end else if (w_shift) begin
          w_next_state = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_next_state = (r_cnt == SHW'(1)) ? ST_DONE : ST_SHIFT;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_op   <= OP_NOP;
    end else begin
      if (w_load) begin
        r_data <= data_in;
      end else if (w_in_shift) begin
        r_data <= w_step_data;
      end
      // Counter holds the bits still to apply; the step at count 1 is the last.
      if (w_shift) begin
        r_op  <= op;
        r_cnt <= shamt;
      end else if (w_in_shift) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign data_out = r_data;
  assign busy     = w_in_shift;
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit (honours SHIFT_ROTATE_EN)
module tb_shift_unit;

  localparam int W = 32;
  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SLL = 3'd2, SRL = 3'd3,
                         SRA = 3'd4, ROL = 3'd5, ROR = 3'd6;
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] data_in;
  logic [4:0]   shamt;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_done(input logic [2:0] o);
    return (o == LOAD) || (o == SLL) || (o == SRL) || (o == SRA) ||
           (ROT && ((o == ROL) || (o == ROR)));
  endfunction

  function automatic logic [W-1:0] model_data(input logic [2:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] d, input int n);
    case (o)
      LOAD:    return d;
      SLL:     return x << n;
      SRL:     return x >> n;
      SRA:     return W'($signed(x) >>> n);
      ROL:     return ROT ? ((x << n) | (x >> (W - n))) : x;
      ROR:     return ROT ? ((x >> n) | (x << (W - n))) : x;
      default: return x;
    endcase
  endfunction

  function automatic int model_busy(input logic [2:0] o, input int n);
    return (model_done(o) && o != LOAD) ? n : 0;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] d, input logic [4:0] n,
                        output int bc, output bit dn);
    start = 1'b1; op = o; data_in = d; shamt = n;
    step();
    start = 1'b0; op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
    bc = 0; dn = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin dn = 1'b1; break; end
      if (!busy) break;
      bc++;
      step();
    end
  endtask

  task automatic test_reset();
    int bc; bit dn;
    reset = 1'b0; start = 1'b0; op = NOP; data_in = '0; shamt = '0;
    step(); step();
    checks++;
    if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got data=%h busy=%b done=%b exp data=0 busy=0 done=0", data_out, busy, done);
    end
    reset = 1'b1;
    run_op(LOAD, 32'hA5A5_0F0F, 5'd0, bc, dn);
    checks++;
    if (dn !== 1'b1 || data_out !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL first_start got done=%b data=%h exp done=1 data=a5a50f0f", dn, data_out);
    end
  endtask

  task automatic test_sra();
    int bc; bit dn;
    run_op(LOAD, 32'h8000_0001, 5'd0, bc, dn);
    run_op(SRA, 32'h0, 5'd4, bc, dn);
    checks++;
    if (bc != 4 || dn !== 1'b1 || data_out !== 32'hF800_0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sra4 got busy_cycles=%0d done=%b data=%h exp 4 1 f8000000", bc, dn, data_out);
    end
  endtask

  task automatic test_sll_zero();
    int bc; bit dn;
    run_op(LOAD, 32'h1234_5678, 5'd0, bc, dn);
    run_op(SLL, 32'hFFFF_FFFF, 5'd0, bc, dn);
    checks++;
    if (bc != 0 || dn !== 1'b1 || data_out !== 32'h1234_5678) begin
      failures++;
      $display("FAIL sll0 got busy_cycles=%0d done=%b data=%h exp 0 1 12345678", bc, dn, data_out);
    end
  endtask

  task automatic test_ror();
    int bc; bit dn;
    bit exp_dn;
    logic [W-1:0] exp_d;
    exp_dn = ROT;
    exp_d  = ROT ? 32'h7812_3456 : 32'h1234_5678;
    run_op(LOAD, 32'h1234_5678, 5'd0, bc, dn);
    run_op(ROR, 32'h0, 5'd8, bc, dn);
    checks++;
    if (dn !== exp_dn || data_out !== exp_d) begin
      failures++;
      $display("FAIL ror8 got done=%b data=%h exp done=%b data=%h", dn, data_out, exp_dn, exp_d);
    end
  endtask

  task automatic test_srl31();
    int bc; bit dn;
    run_op(LOAD, 32'hFFFF_FFFF, 5'd0, bc, dn);
    run_op(SRL, 32'h0, 5'd31, bc, dn);
    checks++;
    if (bc != 31 || dn !== 1'b1 || data_out !== 32'h0000_0001) begin
      failures++;
      $display("FAIL srl31 got busy_cycles=%0d done=%b data=%h exp 31 1 00000001", bc, dn, data_out);
    end
  endtask

  task automatic test_reset_mid();
    int bc; bit dn; bit seen;
    run_op(LOAD, 32'h1, 5'd0, bc, dn);
    start = 1'b1; op = SLL; shamt = 5'd10;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b1 || data_out !== 32'h4) begin
      failures++;
      $display("FAIL mid_shift got busy=%b data=%h exp busy=1 data=00000004", busy, data_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got data=%h busy=%b done=%b exp 0 0 0", data_out, busy, done);
    end
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL post_reset_quiet got activity=%b data=%h exp 0 0", seen, data_out);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit dn;
    logic [W-1:0] x;
    x = $urandom;
    run_op(LOAD, x, 5'd0, bc, dn);
    start = 1'b1; op = SRL; shamt = 5'd5;
    step();
    op = LOAD; data_in = 32'hDEAD_BEEF; shamt = 5'($urandom);
    bc = 0; dn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin dn = 1'b1; break; end
      if (!busy) break;
      bc++;
      step();
    end
    checks++;
    if (bc != 5 || dn !== 1'b1 || data_out !== (x >> 5)) begin
      failures++;
      $display("FAIL load_during_shift got busy_cycles=%0d done=%b data=%h exp 5 1 %h", bc, dn, data_out, x >> 5);
    end
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || data_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL start_in_done got done=%b data=%h exp 1 deadbeef", done, data_out);
    end
  endtask

  task automatic test_random();
    int bc; bit dn;
    logic [W-1:0] cur, d;
    logic [2:0] o;
    logic [4:0] n;
    int bad;
    run_op(LOAD, '0, 5'd0, bc, dn);
    cur = '0;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      d = $urandom;
      n = (i % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 12));
      run_op(o, d, n, bc, dn);
      cur = model_data(o, cur, d, int'(n));
      bad = 0;
      checks++;
      if (dn !== model_done(o) || bc != model_busy(o, int'(n)) || data_out !== cur) begin
        failures++;
        $display("FAIL random[%0d] op=%0d n=%0d got done=%b busy_cycles=%0d data=%h exp %b %0d %h",
                 i, o, n, dn, bc, data_out, model_done(o), model_busy(o, int'(n)), cur);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_sll_zero();
    test_ror();
    test_srl31();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width; shift-amount width is log2(WIDTH), 5 at default.
REQ-002 SHALL have ports clk, input, 1, the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request strobe sampled on a rising clk edge.
REQ-005 SHALL have port op, input, 3, operation code.
REQ-006 SHALL have port data_in, input, WIDTH, operand for LOAD.
REQ-007 SHALL have port shamt, input, 5, shift amount taken from the upstream shift-amount selector.
REQ-008 SHALL have port data_out, output, WIDTH, held shift register contents.
REQ-009 SHALL have port busy, output, 1, high while shifting.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL decode op: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 reserved, treated as NOP.
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 In IDLE or DONE, start=1 with LOAD SHALL capture data_in into data_out at that edge and enter DONE, so done is high the next cycle.
REQ-014 In IDLE or DONE, start=1 with a shift op and shamt>0 SHALL latch op and shamt into a counter and enter SHIFT.
REQ-015 A shift op with shamt=0 SHALL enter DONE directly with data_out unchanged.
REQ-016 Each SHIFT cycle SHALL move data_out by exactly one bit and decrement the counter. SLL and SRL fill with 0. SRA fills with the sign bit. ROL and ROR wrap the vacated bit.
REQ-017 SHIFT SHALL go to DONE on the edge that applies the final bit; a shift issued at edge k yields its final result and done=1 in the cycle after edge k+shamt.
REQ-018 busy SHALL be 1 exactly while in SHIFT.
REQ-019 done SHALL be 1 exactly while in DONE, one cycle. DONE SHALL return to IDLE unless a new start is accepted.
REQ-020 start SHALL be ignored while busy; op and shamt changes during SHIFT SHALL have no effect.
REQ-021 start with NOP or reserved op SHALL leave state and data_out unchanged and produce no done.
REQ-022 data_out SHALL change only on LOAD or shift steps; intermediate values are visible during SHIFT.

Reset
REQ-023 reset low SHALL immediately force state IDLE, data_out 0, counter 0, busy 0, done 0, including mid-shift.
REQ-024 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro SHIFT_ROTATE_EN defined: ROL and ROR SHALL operate per REQ-016.
REQ-026 Macro SHIFT_ROTATE_EN undefined: ROL and ROR SHALL be treated as NOP per REQ-021, and no rotate logic SHALL be synthesized.

Structure
REQ-027 Shared package shift_pkg SHALL hold the op-code constants, the FSM state typedef and the default WIDTH.
REQ-028 Sub-module shift_step SHALL be the one combinational single-bit shift/rotate step, instantiated once; no further hierarchy.

Verification
REQ-029 Sequence: LOAD 0x80000001, then SRA with shamt=4. Required: busy high 4 cycles; done with data_out=0xF8000000.
REQ-030 Sequence: LOAD 0x12345678, then SLL with shamt=0. Required: done the next cycle; data_out=0x12345678; busy never high.
REQ-031 Sequence: LOAD 0x12345678, then ROR with shamt=8.
  With SHIFT_ROTATE_EN: data_out=0x78123456 after done.
  Without SHIFT_ROTATE_EN: no done; data_out unchanged.
REQ-032 Sequence: LOAD 0xFFFFFFFF, then SRL with shamt=31. Required: 31 busy cycles; data_out=0x00000001.
REQ-033 Sequence: SLL with shamt=10 on 0x1, reset pulsed low at the 3rd busy cycle. Required: data_out=0, busy=0, done=0 immediately; no done after release.
REQ-034 Sequence: during an SRL with shamt=5, start with LOAD 0xDEADBEEF. Required: LOAD ignored; SRL result correct; a following start in the DONE cycle is accepted.
